// File: rtl/window_dispatcher_if.sv
// rtl/window_dispatcher_if.sv - window input stream and four-lane output bus
interface window_dispatcher_if #(
    parameter int data_w = 72
);
    logic              in_valid;
    logic              in_ready;
    logic [data_w-1:0] in_data;
    logic [3:0]        lane_ready;
    logic [3:0]        lane_valid;
    logic [data_w-1:0] d_out;
    logic [1:0]        sel;

    modport master (
        input  in_valid, in_data, lane_ready,
        output in_ready, lane_valid, d_out, sel
    );

    modport slave (
        output in_valid, in_data, lane_ready,
        input  in_ready, lane_valid, d_out, sel
    );
endinterface

// File: rtl/window_dispatcher.sv
// rtl/window_dispatcher.sv - window FIFO with round-robin issue to four lanes
module window_dispatcher #(
    parameter int array_size = 9,
    parameter int data_size  = 8,
    parameter int fifo_depth = 4,
    parameter int cnt_width  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    window_dispatcher_if.master           bus,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic [cnt_width-1:0]          disp_count
);
    localparam int DW = data_size * array_size;
    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(fifo_depth);

    logic [DW-1:0]        mem_q [fifo_depth];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [DW-1:0]        d_out_q;
    logic [1:0]           sel_q, rr_ptr_q;
    logic [3:0]           lane_valid_q;
    logic [cnt_width-1:0] disp_q;

    logic       wr_en, xfer, out_free, pop;
    logic       pick_found;
    logic [1:0] pick_off, pick_lane;
    logic [7:0] ready_dbl;
    logic [3:0] ready_rot;

    assign bus.in_ready   = (count_q != CNT_FULL);
    assign bus.lane_valid = lane_valid_q;
    assign bus.d_out      = d_out_q;
    assign bus.sel        = sel_q;
    assign fifo_count     = count_q;
    assign disp_count     = disp_q;

    assign wr_en    = bus.in_valid && bus.in_ready;
    // lane_valid_q is either zero or one-hot at sel_q, so this bit alone marks a pending window
    assign xfer     = lane_valid_q[sel_q] && bus.lane_ready[sel_q];
    assign out_free = (lane_valid_q == 4'b0000) || xfer;

    // Rotate ready so bit 0 is the lane rr_ptr points at; first set bit wins
    assign ready_dbl = {bus.lane_ready, bus.lane_ready};
    assign ready_rot = ready_dbl[rr_ptr_q +: 4];

    always_comb begin
        pick_found = 1'b1;
        pick_off   = 2'd0;
        if (ready_rot[0])      pick_off = 2'd0;
        else if (ready_rot[1]) pick_off = 2'd1;
        else if (ready_rot[2]) pick_off = 2'd2;
        else if (ready_rot[3]) pick_off = 2'd3;
        else                   pick_found = 1'b0;
    end

    assign pick_lane = rr_ptr_q + pick_off;
    assign pop       = out_free && (count_q != '0) && pick_found;

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q      <= '0;
            sel_q        <= 2'd0;
            lane_valid_q <= 4'b0000;
            rr_ptr_q     <= 2'd0;
            disp_q       <= '0;
        end else begin
            if (xfer) disp_q <= disp_q + 1'b1;
            if (pop) begin
                d_out_q      <= mem_q[rd_ptr_q];
                sel_q        <= pick_lane;
                lane_valid_q <= 4'b0001 << pick_lane;
                rr_ptr_q     <= pick_lane + 2'd1;
            end else if (out_free) begin
                lane_valid_q <= 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_window_dispatcher.sv
// tb/tb_window_dispatcher.sv - scoreboard and table-driven bench for window_dispatcher
module tb_window_dispatcher;
    localparam int DW = 72;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    lane;
    } exp_t;

    typedef struct {
        logic [3:0]  ready;
        int          n;
        logic [15:0] lanes;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] fifo_count;
    logic [3:0] disp_count;

    window_dispatcher_if #(.data_w(DW)) bus ();

    window_dispatcher #(
        .array_size(9), .data_size(8), .fifo_depth(4), .cnt_width(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .disp_count (disp_count)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic mask_chk = 1'b0;
    logic [3:0] cur_mask = 4'h0;
    vec_t tbl[4];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [DW-1:0] mkwin(input int k);
        return {32'($urandom), 32'($urandom), 8'(k)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.lane_valid != 4'b0000) begin
            check("lane_valid_onehot", DW'(bus.lane_valid), DW'(4'b0001 << bus.sel));
            if (mask_chk) check("lane_valid_mask", DW'(bus.lane_valid & ~cur_mask), DW'(0));
            if (bus.lane_ready[bus.sel]) begin
                if (sb.size() == 0) fail_now("unexpected_transfer");
                else begin
                    mon_e = sb.pop_front();
                    check("xfer_data", bus.d_out, mon_e.data);
                    check("xfer_sel", DW'(bus.sel), DW'(mon_e.lane));
                end
            end
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic push_window(input logic [DW-1:0] d, input logic [1:0] lane);
        bit   done;
        exp_t e;
        done = 1'b0;
        e.data = d;
        e.lane = lane;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) fail_now("push_timeout");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.lane_valid == 4'b0000 && fifo_count == 3'd0) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w1;
        int accepted;

        tbl[0] = '{ready: 4'hF,    n: 5, lanes: 16'h00E4};
        tbl[1] = '{ready: 4'b1010, n: 4, lanes: 16'h00DD};
        tbl[2] = '{ready: 4'b0100, n: 3, lanes: 16'h002A};
        tbl[3] = '{ready: 4'b1001, n: 4, lanes: 16'h00CC};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.lane_ready = 4'h0;

        do_reset();
        check("rst_fifo_count", DW'(fifo_count), DW'(0));
        check("rst_in_ready",   DW'(bus.in_ready), DW'(1));
        check("rst_lane_valid", DW'(bus.lane_valid), DW'(0));
        check("rst_sel",        DW'(bus.sel), DW'(0));
        check("rst_d_out",      bus.d_out, DW'(0));
        check("rst_disp_count", DW'(disp_count), DW'(0));

        // latency: accepted at edge E, lane_valid visible after E+1
        bus.lane_ready = 4'hF;
        w1 = mkwin(1);
        push_window(w1, 2'd0);
        check("lat_after_E", DW'(bus.lane_valid), DW'(0));
        @(posedge clk);
        #1;
        check("lat_after_E1", DW'(bus.lane_valid), DW'(4'b0001));
        check("lat_d_out", bus.d_out, w1);
        drain();

        for (int t = 0; t < 4; t++) begin
            do_reset();
            bus.lane_ready = tbl[t].ready;
            cur_mask = tbl[t].ready;
            mask_chk = 1'b1;
            for (int j = 0; j < tbl[t].n; j++)
                push_window(mkwin(j + 1), tbl[t].lanes[2*j +: 2]);
            drain();
            mask_chk = 1'b0;
            check("tbl_disp_count", DW'(disp_count), DW'(tbl[t].n));
        end

        // all lanes stalled: FIFO fills to 4 and then blocks
        do_reset();
        bus.lane_ready = 4'h0;
        accepted = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_data = mkwin(accepted + 1);
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{data: bus.in_data, lane: 2'(accepted)});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        check("full_accepted",   DW'(accepted), DW'(4));
        check("full_in_ready",   DW'(bus.in_ready), DW'(0));
        check("full_fifo_count", DW'(fifo_count), DW'(4));
        check("full_lane_valid", DW'(bus.lane_valid), DW'(0));
        bus.in_valid = 1'b0;
        bus.lane_ready = 4'hF;
        drain();
        check("full_in_ready_back", DW'(bus.in_ready), DW'(1));
        check("full_disp_count",    DW'(disp_count), DW'(4));

        // lane 2 stalls with others ready: output held, no reassignment
        do_reset();
        bus.lane_ready = 4'b0100;
        w1 = mkwin(7);
        push_window(w1, 2'd2);
        @(posedge clk);
        #1;
        bus.lane_ready = 4'b1011;
        push_window(mkwin(8), 2'd3);
        check("hold_fifo_count", DW'(fifo_count), DW'(1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_lane_valid", DW'(bus.lane_valid), DW'(4'b0100));
            check("hold_sel",        DW'(bus.sel), DW'(2));
            check("hold_d_out",      bus.d_out, w1);
        end
        @(posedge clk);
        #1;
        bus.lane_ready = 4'hF;
        drain();
        check("hold_disp_count", DW'(disp_count), DW'(2));

        // asynchronous reset with a pending window and a partly full FIFO
        do_reset();
        bus.lane_ready = 4'hF;
        push_window(mkwin(9), 2'd0);
        drain();
        check("ar_pre_disp", DW'(disp_count), DW'(1));
        bus.lane_ready = 4'b0100;
        push_window(mkwin(10), 2'd2);
        @(posedge clk);
        #1;
        bus.lane_ready = 4'h0;
        for (int j = 0; j < 3; j++) push_window(mkwin(11 + j), 2'd0);
        check("ar_pre_count", DW'(fifo_count), DW'(3));
        check("ar_pre_valid", DW'(bus.lane_valid), DW'(4'b0100));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("ar_lane_valid", DW'(bus.lane_valid), DW'(0));
        check("ar_d_out",      bus.d_out, DW'(0));
        check("ar_sel",        DW'(bus.sel), DW'(0));
        check("ar_fifo_count", DW'(fifo_count), DW'(0));
        check("ar_disp_count", DW'(disp_count), DW'(0));
        check("ar_in_ready",   DW'(bus.in_ready), DW'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 17 back-to-back transfers: counter wraps, occupancy steady
        do_reset();
        bus.lane_ready = 4'hF;
        for (int j = 0; j < 17; j++) begin
            push_window(mkwin(j + 1), 2'(j));
            if (j >= 1) check("wrap_fifo_steady", DW'(fifo_count), DW'(1));
        end
        drain();
        check("wrap_disp_count", DW'(disp_count), DW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
